// File: rtl/rr_priority_arbiter.sv
// Registered N-port arbiter: fixed or round-robin priority, optional grant hold with
// request-drop or acknowledge release. Define RR_PRIORITY_ARBITER_GRANT_CNT_EN to add grant_count.
module rr_priority_arbiter #(
   parameter int    PORTS                = 4,
   parameter int    ENC_W                = (PORTS > 1) ? $clog2(PORTS) : 1,
   parameter int    ARB_TYPE_ROUND_ROBIN = 1,
   parameter int    ARB_BLOCK            = 1,
   parameter int    ARB_BLOCK_ACK        = 0,
   parameter string LSB_PRIORITY         = "LOW"
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PORTS-1:0] request,
   input  logic [PORTS-1:0] acknowledge,
   output logic [PORTS-1:0] grant,
   output logic             grant_valid,
   output logic [ENC_W-1:0] grant_encoded
`ifdef RR_PRIORITY_ARBITER_GRANT_CNT_EN
   ,
   output logic [31:0]      grant_count
`endif
);

   localparam bit PRIO_HIGH = (LSB_PRIORITY == "HIGH");
   localparam bit USE_RR    = (ARB_TYPE_ROUND_ROBIN != 0);
   localparam bit USE_BLOCK = (ARB_BLOCK != 0);
   localparam bit USE_ACK   = (ARB_BLOCK != 0) && (ARB_BLOCK_ACK != 0);

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   state_t           state_q, state_d;
   logic [PORTS-1:0] mask_q, mask_d;
   logic [PORTS-1:0] grant_d;
   logic             valid_d;
   logic [ENC_W-1:0] enc_d;

   logic [PORTS-1:0] masked;
   logic [PORTS-1:0] sel_src;
   logic [ENC_W-1:0] sel_idx;
   logic             any_req;
   logic             hold_release;
   logic             arb;
   logic             new_grant;

   // Lowest set index wins for "LOW", highest for "HIGH": the last hit in the loop order wins.
   function automatic logic [ENC_W-1:0] prio_enc(input logic [PORTS-1:0] vec);
      logic [ENC_W-1:0] idx;
      idx = '0;
      if (PRIO_HIGH) begin
         for (int i = 0; i < PORTS; i++)
            if (vec[i]) idx = ENC_W'(i);
      end else begin
         for (int i = PORTS - 1; i >= 0; i--)
            if (vec[i]) idx = ENC_W'(i);
      end
      return idx;
   endfunction

   // Mask keeps only ports strictly behind the winner in priority order; empty reloads to all ones.
   function automatic logic [PORTS-1:0] next_mask(input logic [ENC_W-1:0] k);
      logic [PORTS-1:0] m;
      m = '0;
      for (int i = 0; i < PORTS; i++)
         m[i] = PRIO_HIGH ? (i < int'(k)) : (i > int'(k));
      if (m == '0) m = '1;
      return m;
   endfunction

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      masked       = request & mask_q;
      sel_src      = (USE_RR && (masked != '0)) ? masked : request;
      sel_idx      = prio_enc(sel_src);
      any_req      = (request != '0);
      hold_release = USE_ACK ? acknowledge[grant_encoded] : !request[grant_encoded];

      state_d   = state_q;
      mask_d    = mask_q;
      grant_d   = grant;
      valid_d   = grant_valid;
      enc_d     = grant_encoded;
      new_grant = 1'b0;

      if (!USE_BLOCK) begin
         arb = 1'b1;
      end else begin
         case (state_q)
            IDLE:    arb = 1'b1;
            HOLD:    arb = hold_release;
            default: arb = 1'b1;
         endcase
      end

      if (arb) begin
         if (any_req) begin
            grant_d          = '0;
            grant_d[sel_idx] = 1'b1;
            valid_d          = 1'b1;
            enc_d            = sel_idx;
            state_d          = USE_BLOCK ? HOLD : IDLE;
            if (USE_RR) mask_d = next_mask(sel_idx);
            new_grant = USE_BLOCK ? 1'b1 : (!grant_valid || (sel_idx != grant_encoded));
         end else begin
            // Encoded index is left at its last value while nothing is granted.
            grant_d = '0;
            valid_d = 1'b0;
            state_d = IDLE;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         mask_q        <= '1;
         grant         <= '0;
         grant_valid   <= 1'b0;
         grant_encoded <= '0;
      end else begin
         state_q       <= state_d;
         mask_q        <= mask_d;
         grant         <= grant_d;
         grant_valid   <= valid_d;
         grant_encoded <= enc_d;
      end
   end

`ifdef RR_PRIORITY_ARBITER_GRANT_CNT_EN
   logic [31:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            count_q <= '0;
      else if (new_grant) count_q <= count_q + 32'd1;
   end

   assign grant_count = count_q;
`else
   logic unused_new_grant;
   assign unused_new_grant = new_grant;
`endif

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench for rr_priority_arbiter: four configurations share clk/rst, expectations
// are queued when stimulus is driven and compared after the following clock edge.
module tb_rr_priority_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req_rr, req_fx, req_ack, req_blk;
   logic [3:0] ack_ack;
   logic [3:0] zero4;
   logic [3:0] g_rr, g_fx, g_ack, g_blk;
   logic       v_rr, v_fx, v_ack, v_blk;
   logic [1:0] e_rr, e_fx, e_ack, e_blk;
`ifdef RR_PRIORITY_ARBITER_GRANT_CNT_EN
   logic [31:0] c_rr, c_fx, c_ack, c_blk;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         dut;
      string      tag;
      logic [3:0] grant;
      logic [1:0] enc;
   } exp_t;

   exp_t sb[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   rr_priority_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0),
                         .LSB_PRIORITY("LOW")) u_rr (
      .clk(clk), .rst(rst), .request(req_rr), .acknowledge(zero4),
      .grant(g_rr), .grant_valid(v_rr), .grant_encoded(e_rr)
`ifdef RR_PRIORITY_ARBITER_GRANT_CNT_EN
      , .grant_count(c_rr)
`endif
   );

   rr_priority_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0),
                         .LSB_PRIORITY("HIGH")) u_fx (
      .clk(clk), .rst(rst), .request(req_fx), .acknowledge(zero4),
      .grant(g_fx), .grant_valid(v_fx), .grant_encoded(e_fx)
`ifdef RR_PRIORITY_ARBITER_GRANT_CNT_EN
      , .grant_count(c_fx)
`endif
   );

   rr_priority_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
                         .LSB_PRIORITY("LOW")) u_ack (
      .clk(clk), .rst(rst), .request(req_ack), .acknowledge(ack_ack),
      .grant(g_ack), .grant_valid(v_ack), .grant_encoded(e_ack)
`ifdef RR_PRIORITY_ARBITER_GRANT_CNT_EN
      , .grant_count(c_ack)
`endif
   );

   rr_priority_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
                         .LSB_PRIORITY("LOW")) u_blk (
      .clk(clk), .rst(rst), .request(req_blk), .acknowledge(zero4),
      .grant(g_blk), .grant_valid(v_blk), .grant_encoded(e_blk)
`ifdef RR_PRIORITY_ARBITER_GRANT_CNT_EN
      , .grant_count(c_blk)
`endif
   );

   function automatic logic [3:0] obs_grant(input int d);
      case (d)
         0:       return g_rr;
         1:       return g_fx;
         2:       return g_ack;
         default: return g_blk;
      endcase
   endfunction

   function automatic logic obs_valid(input int d);
      case (d)
         0:       return v_rr;
         1:       return v_fx;
         2:       return v_ack;
         default: return v_blk;
      endcase
   endfunction

   function automatic logic [1:0] obs_enc(input int d);
      case (d)
         0:       return e_rr;
         1:       return e_fx;
         2:       return e_ack;
         default: return e_blk;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int d, input string tag, input logic [3:0] g, input logic [1:0] e);
      exp_t x;
      x.dut   = d;
      x.tag   = tag;
      x.grant = g;
      x.enc   = e;
      sb.push_back(x);
   endtask

   task automatic drain();
      exp_t x;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         check({x.tag, "_grant"}, {28'd0, obs_grant(x.dut)}, {28'd0, x.grant});
         check({x.tag, "_valid"}, {31'd0, obs_valid(x.dut)}, {31'd0, |x.grant});
         check({x.tag, "_enc"},   {30'd0, obs_enc(x.dut)},   {30'd0, x.enc});
      end
   endtask

   // Advance one rising edge, then compare on the falling edge.
   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
      drain();
   endtask

   initial begin
      rst     = 1'b0;
      req_rr  = '0;
      req_fx  = '0;
      req_ack = '0;
      req_blk = '0;
      ack_ack = '0;
      zero4   = '0;
      #1 rst  = 1'b1;
      #1;
      for (int d = 0; d < 4; d++) push_exp(d, "reset", 4'b0000, 2'd0);
      drain();
      @(negedge clk);
      rst = 1'b0;

      // Idle after reset.
      for (int c = 0; c < 5; c++) begin
         for (int d = 0; d < 4; d++) push_exp(d, "idle", 4'b0000, 2'd0);
         cycle();
      end

      // Round-robin, no hold: all requesting rotates 0..3 twice.
      req_rr = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         push_exp(0, "rr_rot", 4'b0001 << (c % 4), 2'(c % 4));
         cycle();
      end
      req_rr = 4'b0000;
      push_exp(0, "rr_drop_enc_held", 4'b0000, 2'd3);
      cycle();
      req_rr = 4'b1010;
      push_exp(0, "rr_1010_a", 4'b0010, 2'd1);
      cycle();
      push_exp(0, "rr_1010_b", 4'b1000, 2'd3);
      cycle();
      push_exp(0, "rr_1010_c", 4'b0010, 2'd1);
      cycle();
      req_rr = 4'b0000;

      // Fixed priority, index 3 highest.
      req_fx = 4'b0101;
      for (int c = 0; c < 3; c++) begin
         push_exp(1, "fx_0101", 4'b0100, 2'd2);
         cycle();
      end
      req_fx = 4'b0011;
      push_exp(1, "fx_0011", 4'b0010, 2'd1);
      cycle();
      req_fx = 4'b1111;
      push_exp(1, "fx_1111_a", 4'b1000, 2'd3);
      cycle();
      push_exp(1, "fx_1111_b", 4'b1000, 2'd3);
      cycle();
      req_fx = 4'b0001;
      push_exp(1, "fx_0001", 4'b0001, 2'd0);
      cycle();
      req_fx = 4'b0000;

      // Hold with acknowledge release.
      req_ack = 4'b0011;
      push_exp(2, "ack_first", 4'b0001, 2'd0);
      cycle();
      req_ack = 4'b0010;
      push_exp(2, "ack_hold_reqchg", 4'b0001, 2'd0);
      cycle();
      ack_ack = 4'b0100;
      push_exp(2, "ack_wrong_idx", 4'b0001, 2'd0);
      cycle();
      ack_ack = 4'b0001;
      push_exp(2, "ack_release", 4'b0010, 2'd1);
      cycle();
      ack_ack = 4'b0000;
      req_ack = 4'b0000;
      push_exp(2, "ack_hold_noreq", 4'b0010, 2'd1);
      cycle();
      ack_ack = 4'b0010;
      push_exp(2, "ack_to_idle", 4'b0000, 2'd1);
      cycle();
      ack_ack = 4'b1111;
      push_exp(2, "ack_in_idle", 4'b0000, 2'd1);
      cycle();
      ack_ack = 4'b0000;
      req_ack = 4'b0110;
      push_exp(2, "ack_grant2", 4'b0100, 2'd2);
      cycle();
      ack_ack = 4'b0100;
      push_exp(2, "ack_rerequest_masked", 4'b0010, 2'd1);
      cycle();
      ack_ack = 4'b0000;
      req_ack = 4'b0000;
      push_exp(2, "ack_hold_again", 4'b0010, 2'd1);
      cycle();
      ack_ack = 4'b0010;
      push_exp(2, "ack_idle_again", 4'b0000, 2'd1);
      cycle();
      ack_ack = 4'b0000;

      // Hold with request-drop release and direct handoff.
      req_blk = 4'b1000;
      push_exp(3, "blk_grant3", 4'b1000, 2'd3);
      cycle();
      req_blk = 4'b1110;
      push_exp(3, "blk_hold3", 4'b1000, 2'd3);
      cycle();
      req_blk = 4'b0110;
      push_exp(3, "blk_handoff_wrap", 4'b0010, 2'd1);
      cycle();
      push_exp(3, "blk_hold1", 4'b0010, 2'd1);
      cycle();
      req_blk = 4'b0100;
      push_exp(3, "blk_handoff2", 4'b0100, 2'd2);
      cycle();
      req_blk = 4'b1100;
      push_exp(3, "blk_hold2", 4'b0100, 2'd2);
      cycle();
      req_blk = 4'b1000;
      push_exp(3, "blk_handoff3", 4'b1000, 2'd3);
      cycle();
      push_exp(3, "blk_hold3b", 4'b1000, 2'd3);
      cycle();
`ifdef RR_PRIORITY_ARBITER_GRANT_CNT_EN
      check("blk_count_before_rst", c_blk, 32'd4);
`endif

      // Asynchronous reset in the middle of a hold.
      rst = 1'b1;
      #1;
      push_exp(3, "blk_async_rst", 4'b0000, 2'd0);
      drain();
`ifdef RR_PRIORITY_ARBITER_GRANT_CNT_EN
      check("blk_count_rst", c_blk, 32'd0);
`endif
      @(negedge clk);
      push_exp(3, "blk_in_rst", 4'b0000, 2'd0);
      drain();
      rst = 1'b0;
      push_exp(3, "blk_after_rst", 4'b1000, 2'd3);
      cycle();
`ifdef RR_PRIORITY_ARBITER_GRANT_CNT_EN
      check("blk_count_after_rst", c_blk, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
